// File: rtl/route_arb_pkg.sv
// Shared types and constants for the route_arb2 flit-select arbiter.
package route_arb_pkg;

  localparam int unsigned FLIT_W   = 11;
  localparam int unsigned TAIL_BIT = 10;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

endpackage

// File: rtl/route_arb2_rr_pick2.sv
// Two-way round-robin pick with an optional lock that restricts eligibility to one input.
module rr_pick2
  import route_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_en,
  input  logic       lock_owner,
  output logic       gnt_valid,
  output logic       gnt_sel
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = SEL_X;
    if (lock_en) begin
      gnt_valid = req[lock_owner];
      gnt_sel   = lock_owner;
    end else begin
      unique case (req)
        2'b01:   begin gnt_valid = 1'b1; gnt_sel = SEL_X; end
        2'b10:   begin gnt_valid = 1'b1; gnt_sel = SEL_Y; end
        2'b11:   begin gnt_valid = 1'b1; gnt_sel = ~last_grant; end
        default: begin gnt_valid = 1'b0; gnt_sel = SEL_X; end
      endcase
    end
  end

endmodule

// File: rtl/route_arb2.sv
// Issues one mux select token per flit from snooped X/Y handshakes, round-robin.
// Define ROUTE_ARB_PKT_LOCK_EN to hold the grant on one input until a tail flit passes.
module route_arb2
  import route_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              x_valid,
  input  logic              x_ready,
  input  logic [FLIT_W-1:0] x_data,
  input  logic              y_valid,
  input  logic              y_ready,
  input  logic [FLIT_W-1:0] y_data,
  output logic              c_valid,
  input  logic              c_ready,
  output logic              c_data,
  output logic              locked,
  output logic              owner
);

  state_t state, state_nxt;
  logic   c_valid_nxt, c_data_nxt, owner_nxt, locked_nxt;
  logic   last_grant, last_grant_nxt;
  logic   gnt_valid, gnt_sel;
  logic   own_xfer;
  logic   unused_data;

  // Only the tail flag of each flit matters here.
  assign unused_data = ^{x_data, y_data};

  assign own_xfer = owner ? (y_valid & y_ready) : (x_valid & x_ready);

`ifdef ROUTE_ARB_PKT_LOCK_EN
  logic own_tail;
  assign own_tail = owner ? y_data[TAIL_BIT] : x_data[TAIL_BIT];
`endif

  rr_pick2 u_pick (
    .req        ({y_valid, x_valid}),
    .last_grant (last_grant),
    .lock_en    (locked),
    .lock_owner (owner),
    .gnt_valid  (gnt_valid),
    .gnt_sel    (gnt_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      c_valid    <= 1'b0;
      c_data     <= SEL_X;
      owner      <= SEL_X;
      locked     <= 1'b0;
      last_grant <= SEL_Y;
    end else begin
      state      <= state_nxt;
      c_valid    <= c_valid_nxt;
      c_data     <= c_data_nxt;
      owner      <= owner_nxt;
      locked     <= locked_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    c_valid_nxt    = c_valid;
    c_data_nxt     = c_data;
    owner_nxt      = owner;
    locked_nxt     = locked;
    last_grant_nxt = last_grant;
    unique case (state)
      ARB: begin
        if (gnt_valid) begin
          c_valid_nxt = 1'b1;
          c_data_nxt  = gnt_sel;
          owner_nxt   = gnt_sel;
          state_nxt   = GRANT;
        end
      end
      GRANT: begin
        if (c_ready) begin
          c_valid_nxt = 1'b0;
          state_nxt   = XFER;
        end
      end
      XFER: begin
        // Non-owner handshakes are ignored; only the granted flit closes the token.
        if (own_xfer) begin
          last_grant_nxt = owner;
`ifdef ROUTE_ARB_PKT_LOCK_EN
          locked_nxt     = ~own_tail;
`else
          locked_nxt     = 1'b0;
`endif
          state_nxt      = ARB;
        end
      end
      default: begin
        state_nxt   = ARB;
        c_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_route_arb2.sv
// Self-checking bench for route_arb2: directed scenarios plus randomized traffic vs a flit-level model.
module tb_route_arb2;
  import route_arb_pkg::*;

`ifdef ROUTE_ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              x_valid, x_ready, y_valid, y_ready, c_ready;
  logic [FLIT_W-1:0] x_data, y_data;
  logic              c_valid, c_data, locked, owner;

  int total = 0;
  int bad   = 0;

  // Flit-level model: who was served last and whether a packet is still open.
  bit m_last;
  bit m_locked;

  always #5 clk = ~clk;

  route_arb2 dut (
    .clk     (clk),
    .reset   (reset),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_data  (c_data),
    .locked  (locked),
    .owner   (owner)
  );

  function automatic logic [FLIT_W-1:0] flit(input bit tail);
    logic [FLIT_W-1:0] f;
    f = FLIT_W'($urandom);
    f[TAIL_BIT] = tail;
    return f;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    x_valid = 1'b0; x_ready = 1'b0; y_valid = 1'b0; y_ready = 1'b0; c_ready = 1'b0;
    x_data = '0; y_data = '0;
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;
    m_locked = 1'b0;
  endtask

  task automatic wait_cvalid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (c_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Acts as the mux: take the token, then move the selected flit one cycle later.
  task automatic serve(input int stall, input bit next_valid, output bit ok, output bit sel);
    sel = 1'b0;
    c_ready = 1'b0;
    wait_cvalid(10, ok);
    if (!ok) return;
    sel = c_data;
    repeat (stall) @(negedge clk);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    if (sel) y_ready = 1'b1; else x_ready = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    y_ready = 1'b0;
    if (sel) y_valid = next_valid; else x_valid = next_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x_valid = 1'b0; x_ready = 1'b0; y_valid = 1'b0; y_ready = 1'b0; c_ready = 1'b0;
    x_data = '0; y_data = '0;
    @(negedge clk);
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL reset_c_valid: got %b want 0", c_valid); end
    total++; if (c_data !== 1'b0) begin bad++; $display("FAIL reset_c_data: got %b want 0", c_data); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner: got %b want 0", owner); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    reset = 1'b0;
    m_last = 1'b1;
    m_locked = 1'b0;
  endtask

  task automatic test_single_x();
    do_reset();
    c_ready = 1'b1;
    x_valid = 1'b1;
    x_data = flit(1'b1);
    @(negedge clk);
    total++;
    if ({c_valid, c_data} !== {1'b1, SEL_X}) begin
      bad++; $display("FAIL single_grant: got valid=%b data=%b want valid=1 data=0", c_valid, c_data);
    end
    total++; if (owner !== SEL_X) begin bad++; $display("FAIL single_owner: got %b want 0", owner); end
    @(negedge clk);
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL single_consumed: got %b want 0", c_valid); end
    x_ready = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    x_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", c_valid); end
    y_valid = 1'b1;
    y_data = flit(1'b1);
    @(negedge clk);
    total++;
    if ({c_valid, c_data} !== {1'b1, SEL_Y}) begin
      bad++; $display("FAIL single_back_in_arb: got valid=%b data=%b want valid=1 data=1", c_valid, c_data);
    end
    @(negedge clk);
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    y_valid = 1'b0;
    c_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok, sel;
    do_reset();
    x_valid = 1'b1; x_data = flit(1'b1);
    y_valid = 1'b1; y_data = flit(1'b1);
    wait_cvalid(5, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_token: got none want token"); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({c_valid, c_data} !== {1'b1, SEL_X}) begin
        bad++; $display("FAIL stall_hold[%0d]: got valid=%b data=%b want valid=1 data=0", i, c_valid, c_data);
      end
      @(negedge clk);
    end
    c_ready = 1'b1;
    @(negedge clk);
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL stall_accept: got %b want 0", c_valid); end
    repeat (2) @(negedge clk);
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL stall_single_token: got %b want 0", c_valid); end
    c_ready = 1'b0;
    x_ready = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    x_data = flit(1'b1);
    serve(0, 1'b1, ok, sel);
    total++;
    if (!ok || sel !== SEL_Y) begin bad++; $display("FAIL stall_next_rr: got ok=%0b sel=%b want sel=1", ok, sel); end
  endtask

  task automatic test_tie();
    bit ok, sel;
    do_reset();
    x_valid = 1'b1; x_data = flit(1'b1);
    y_valid = 1'b1; y_data = flit(1'b1);
    for (int i = 0; i < 4; i++) begin
      serve($urandom_range(0, 2), 1'b1, ok, sel);
      total++;
      if (!ok || sel !== 1'(i % 2)) begin
        bad++; $display("FAIL tie_seq[%0d]: got ok=%0b sel=%b want sel=%0d", i, ok, sel, i % 2);
      end
    end
  endtask

  task automatic test_lock_packet();
    bit ok, sel, tail, exp_sel, nv;
    bit [3:0] seq;
    int xcnt;
    do_reset();
    seq = LOCK_EN ? 4'b1000 : 4'b1010;
    xcnt = 0;
    x_valid = 1'b1; x_data = flit(1'b0);
    y_valid = 1'b1; y_data = flit(1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_sel = seq[i];
      tail = exp_sel ? y_data[TAIL_BIT] : x_data[TAIL_BIT];
      nv = exp_sel ? 1'b1 : (xcnt < 2);
      serve(0, nv, ok, sel);
      total++;
      if (!ok || sel !== exp_sel) begin
        bad++; $display("FAIL lock_seq[%0d]: got ok=%0b sel=%b want sel=%b", i, ok, sel, exp_sel);
      end
      total++;
      if (locked !== (LOCK_EN && !exp_sel && !tail)) begin
        bad++; $display("FAIL lock_flag[%0d]: got %b want %b", i, locked, LOCK_EN && !exp_sel && !tail);
      end
      if (exp_sel) y_data = flit(1'b1);
      else begin
        xcnt++;
        x_data = flit(xcnt == 2);
      end
    end
  endtask

  task automatic test_lock_exclusive();
    bit ok, sel;
    do_reset();
    x_valid = 1'b1; x_data = flit(1'b0);
    serve(0, 1'b0, ok, sel);
    total++; if (!ok || sel !== SEL_X) begin bad++; $display("FAIL excl_first: got ok=%0b sel=%b want sel=0", ok, sel); end
    total++; if (locked !== LOCK_EN) begin bad++; $display("FAIL excl_locked: got %b want %b", locked, LOCK_EN); end
    y_valid = 1'b1; y_data = flit(1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (c_valid !== !LOCK_EN) begin bad++; $display("FAIL excl_other_only: got c_valid=%b want %b", c_valid, !LOCK_EN); end
    x_valid = 1'b1; x_data = flit(1'b1);
    serve(0, 1'b0, ok, sel);
    total++;
    if (!ok || sel !== !LOCK_EN) begin bad++; $display("FAIL excl_second: got ok=%0b sel=%b want sel=%b", ok, sel, !LOCK_EN); end
  endtask

  task automatic test_reset_mid_xfer();
    bit ok, sel;
    do_reset();
    x_valid = 1'b1; x_data = flit(1'b0);
    y_valid = 1'b1; y_data = flit(1'b1);
    serve(0, 1'b1, ok, sel);
    total++; if (!ok || sel !== SEL_X) begin bad++; $display("FAIL rmid_first: got ok=%0b sel=%b want sel=0", ok, sel); end
    x_data = flit(1'b0);
    wait_cvalid(5, ok);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    total++; if (locked !== LOCK_EN) begin bad++; $display("FAIL rmid_locked: got %b want %b", locked, LOCK_EN); end
    #2 reset = 1'b1;
    #1;
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL rmid_c_valid: got %b want 0", c_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rmid_lock_clear: got %b want 0", locked); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL rmid_owner: got %b want 0", owner); end
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;
    m_locked = 1'b0;
    serve(0, 1'b1, ok, sel);
    total++; if (!ok || sel !== SEL_X) begin bad++; $display("FAIL rmid_tie_x: got ok=%0b sel=%b want sel=0", ok, sel); end
  endtask

  task automatic test_nonowner();
    bit ok, sel;
    do_reset();
    c_ready = 1'b1;
    x_valid = 1'b1; x_data = flit(1'b1);
    y_valid = 1'b1; y_data = flit(1'b1);
    @(negedge clk);
    total++;
    if ({c_valid, c_data} !== {1'b1, SEL_X}) begin
      bad++; $display("FAIL nonown_grant: got valid=%b data=%b want valid=1 data=0", c_valid, c_data);
    end
    @(negedge clk);
    c_ready = 1'b0;
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    @(negedge clk);
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL nonown_ignored: got c_valid=%b want 0", c_valid); end
    total++; if (owner !== SEL_X) begin bad++; $display("FAIL nonown_owner: got %b want 0", owner); end
    x_ready = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    x_valid = 1'b0;
    serve(0, 1'b0, ok, sel);
    total++; if (!ok || sel !== SEL_Y) begin bad++; $display("FAIL nonown_next: got ok=%0b sel=%b want sel=1", ok, sel); end
  endtask

  task automatic test_random(input int n);
    bit ok, sel, exp_sel, tail;
    do_reset();
    x_valid = 1'($urandom_range(0, 1)); x_data = flit(1'($urandom_range(0, 1)));
    y_valid = 1'($urandom_range(0, 1)); y_data = flit(1'($urandom_range(0, 1)));
    for (int i = 0; i < n; i++) begin
      if (m_locked) begin
        if (m_last) y_valid = 1'b1; else x_valid = 1'b1;
      end else if (!x_valid && !y_valid) begin
        if ($urandom_range(0, 1) == 1) y_valid = 1'b1; else x_valid = 1'b1;
      end
      if (m_locked) exp_sel = m_last;
      else if (x_valid && y_valid) exp_sel = !m_last;
      else exp_sel = y_valid;
      tail = exp_sel ? y_data[TAIL_BIT] : x_data[TAIL_BIT];
      serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), ok, sel);
      total++;
      if (!ok || sel !== exp_sel) begin
        bad++; $display("FAIL rand_sel[%0d]: got ok=%0b sel=%b want sel=%b", i, ok, sel, exp_sel);
      end
      m_last = exp_sel;
      m_locked = LOCK_EN && !tail;
      total++;
      if (locked !== m_locked) begin
        bad++; $display("FAIL rand_locked[%0d]: got %b want %b", i, locked, m_locked);
      end
      if (exp_sel) y_data = flit(1'($urandom_range(0, 1)));
      else x_data = flit(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_x();
    test_stall();
    test_tie();
    test_lock_packet();
    test_lock_exclusive();
    test_reset_mid_xfer();
    test_nonowner();
    test_random(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
